// File: rtl/ysyx_core_ctrl.sv
// ysyx_core_ctrl: multi-cycle IF/ID/EX/MEM/WB sequencer for the RV32 core.
// Drives the fetch and load/store handshakes, holds the fetched instruction
// and emits one rf_wen/pc_wen pulse per retired instruction.
// Halts on ebreak, an illegal opcode or a handshake timeout.
// Optional macro YSYX_CTRL_PERF_EN adds perf_cycle/perf_instret counters.
//
// state | meaning
// IDLE  | waiting for run_en
// IF    | fetch request outstanding
// ID    | decode latched instruction
// EX    | execute, pick MEM or WB
// MEM   | load/store request outstanding
// WB    | retire: pc_wen, optional rf_wen
// HALT  | stopped until reset
module ysyx_core_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_en,
  output logic        ifu_req,
  input  logic        ifu_ack,
  input  logic [31:0] ifu_rdata,
  output logic [31:0] inst,
  output logic        lsu_req,
  output logic        lsu_wr,
  input  logic        lsu_ack,
  output logic        rf_wen,
  output logic        pc_wen,
  output logic        halt,
  output logic        bad_inst,
  output logic        bus_err,
  output logic [2:0]  state
`ifdef YSYX_CTRL_PERF_EN
  ,
  output logic [63:0] perf_cycle,
  output logic [63:0] perf_instret
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } st_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Timeout fires on the cycle the wait counter would reach TIMEOUT.
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  st_e             cur, nxt;
  logic [TO_W-1:0] cnt;
  logic            to_hit;
  logic            latch_inst, set_bad, set_bus;
  logic [6:0]      opc;
  logic            is_ebreak, is_load, is_store, legal, writes_rd;

  assign opc       = inst[6:0];
  assign is_ebreak = (inst == 32'h00100073);
  assign is_load   = (opc == OP_LOAD);
  assign is_store  = (opc == OP_STORE);
  assign writes_rd = (opc == OP_LUI) || (opc == OP_AUIPC) || (opc == OP_IMM) ||
                     (opc == OP_OP) || (opc == OP_JAL) || (opc == OP_JALR) || is_load;
  assign legal     = writes_rd || is_store || (opc == OP_BRANCH) ||
                     ((opc == OP_SYSTEM) && is_ebreak);
  assign to_hit    = (TIMEOUT != 0) && (cnt == TO_LAST);
  assign halt      = (cur == S_HALT);
  assign state     = cur;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;
  end

  // Next-state decode and Moore handshake/strobe outputs.
  always_comb begin
    nxt        = cur;
    ifu_req    = 1'b0;
    lsu_req    = 1'b0;
    lsu_wr     = 1'b0;
    rf_wen     = 1'b0;
    pc_wen     = 1'b0;
    latch_inst = 1'b0;
    set_bad    = 1'b0;
    set_bus    = 1'b0;
    case (cur)
      S_IDLE: if (run_en) nxt = S_IF;
      S_IF: begin
        ifu_req = 1'b1;
        if (ifu_ack) begin
          latch_inst = 1'b1;
          nxt        = S_ID;
        end else if (to_hit) begin
          set_bus = 1'b1;
          nxt     = S_HALT;
        end
      end
      S_ID: begin
        if (!legal) begin
          set_bad = 1'b1;
          nxt     = S_HALT;
        end else if (is_ebreak) begin
          nxt = S_HALT;
        end else begin
          nxt = S_EX;
        end
      end
      S_EX: nxt = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM: begin
        lsu_req = 1'b1;
        lsu_wr  = is_store;
        if (lsu_ack) begin
          nxt = S_WB;
        end else if (to_hit) begin
          set_bus = 1'b1;
          nxt     = S_HALT;
        end
      end
      S_WB: begin
        pc_wen = 1'b1;
        rf_wen = writes_rd && (inst[11:7] != 5'd0);
        nxt    = run_en ? S_IF : S_IDLE;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
  end

  // Wait counter: runs only while a request is unanswered, zero otherwise,
  // so it is already clear on every entry to IF or MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if ((cur == S_IF && !ifu_ack) || (cur == S_MEM && !lsu_ack))
      cnt <= cnt + 1'b1;
    else
      cnt <= '0;
  end

  // Instruction latch and sticky halt causes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst     <= 32'd0;
      bad_inst <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      if (latch_inst) inst <= ifu_rdata;
      if (set_bad) bad_inst <= 1'b1;
      if (set_bus) bus_err  <= 1'b1;
    end
  end

`ifdef YSYX_CTRL_PERF_EN
  // Active-cycle and retired-instruction counters, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycle   <= 64'd0;
      perf_instret <= 64'd0;
    end else begin
      if (cur != S_IDLE && cur != S_HALT) perf_cycle <= perf_cycle + 64'd1;
      if (pc_wen) perf_instret <= perf_instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_core_ctrl.sv
// Directed bench for ysyx_core_ctrl with TIMEOUT = 4.
module tb_ysyx_core_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n, run_en, ifu_ack, lsu_ack;
  logic [31:0] ifu_rdata;
  logic        ifu_req, lsu_req, lsu_wr, rf_wen, pc_wen, halt, bad_inst, bus_err;
  logic [31:0] inst;
  logic [2:0]  state;
`ifdef YSYX_CTRL_PERF_EN
  logic [63:0] perf_cycle, perf_instret;
`endif

  ysyx_core_ctrl #(.TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en),
    .ifu_req(ifu_req), .ifu_ack(ifu_ack), .ifu_rdata(ifu_rdata),
    .inst(inst), .lsu_req(lsu_req), .lsu_wr(lsu_wr), .lsu_ack(lsu_ack),
    .rf_wen(rf_wen), .pc_wen(pc_wen), .halt(halt), .bad_inst(bad_inst),
    .bus_err(bus_err), .state(state)
`ifdef YSYX_CTRL_PERF_EN
    , .perf_cycle(perf_cycle), .perf_instret(perf_instret)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] ins;
    int          ack_wait;
    bit          exp_mem;
    bit          exp_wr;
    bit          exp_rf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    run_en  = 1'b0;
    ifu_ack = 1'b0;
    lsu_ack = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Entered at a negedge with the DUT in IF; leaves at the negedge after WB.
  task automatic run_inst(input int idx, input logic [31:0] ins, input int ack_wait,
                          input bit exp_mem, input bit exp_wr, input bit exp_rf);
    chk($sformatf("v%0d if_state", idx), state, 3'd1);
    chk($sformatf("v%0d if_req", idx), ifu_req, 1'b1);
    ifu_ack   = 1'b1;
    ifu_rdata = ins;
    step();
    ifu_ack   = 1'b0;
    ifu_rdata = 32'hDEADBEEF;
    chk($sformatf("v%0d id_state", idx), state, 3'd2);
    chk($sformatf("v%0d id_inst", idx), inst, ins);
    chk($sformatf("v%0d id_strobes", idx), {rf_wen, pc_wen}, 2'b00);
    step();
    chk($sformatf("v%0d ex_state", idx), state, 3'd3);
    step();
    if (exp_mem) begin
      for (int k = 0; k <= ack_wait; k++) begin
        chk($sformatf("v%0d mem_state", idx), state, 3'd4);
        chk($sformatf("v%0d mem_req", idx), {lsu_req, lsu_wr}, {1'b1, exp_wr});
        chk($sformatf("v%0d mem_rf", idx), rf_wen, 1'b0);
        lsu_ack = (k == ack_wait);
        step();
        lsu_ack = 1'b0;
      end
    end
    chk($sformatf("v%0d wb_state", idx), state, 3'd5);
    chk($sformatf("v%0d wb_pc", idx), pc_wen, 1'b1);
    chk($sformatf("v%0d wb_rf", idx), rf_wen, exp_rf);
    chk($sformatf("v%0d wb_lsu", idx), lsu_req, 1'b0);
    step();
  endtask

  initial begin
    vecs[0] = '{32'h00500093, 0, 1'b0, 1'b0, 1'b1}; // addi x1,x0,5
    vecs[1] = '{32'h0000A103, 3, 1'b1, 1'b0, 1'b1}; // lw x2,0(x1), late ack
    vecs[2] = '{32'h0020A023, 0, 1'b1, 1'b1, 1'b0}; // sw x2,0(x1)
    vecs[3] = '{32'h00000013, 0, 1'b0, 1'b0, 1'b0}; // nop, rd = x0
    vecs[4] = '{32'h000122B7, 0, 1'b0, 1'b0, 1'b1}; // lui x5
    vecs[5] = '{32'h002081B3, 0, 1'b0, 1'b0, 1'b1}; // add x3,x1,x2
    vecs[6] = '{32'h00208463, 0, 1'b0, 1'b0, 1'b0}; // beq
    vecs[7] = '{32'h008000EF, 0, 1'b0, 1'b0, 1'b1}; // jal x1
    vecs[8] = '{32'h00008067, 0, 1'b0, 1'b0, 1'b0}; // jalr x0
    vecs[9] = '{32'h00000217, 2, 1'b0, 1'b0, 1'b1}; // auipc x4

    rst_n = 1'b1; run_en = 1'b0; ifu_ack = 1'b0; lsu_ack = 1'b0; ifu_rdata = 32'd0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst state", state, 3'd0);
    chk("rst inst", inst, 32'd0);
    chk("rst flags", {halt, bad_inst, bus_err, rf_wen, pc_wen, ifu_req, lsu_req}, 7'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("idle hold", state, 3'd0);

    // Reset while a load is waiting in MEM.
    run_en = 1'b1;
    step();
    chk("pre_rst if", state, 3'd1);
    ifu_ack = 1'b1; ifu_rdata = 32'h0000A103;
    step();
    ifu_ack = 1'b0;
    step();
    step();
    chk("pre_rst mem req", {state, lsu_req}, {3'd4, 1'b1});
    rst_n = 1'b0;
    run_en = 1'b0;
    #1;
    chk("midmem rst lsu_req", lsu_req, 1'b0);
    chk("midmem rst state", state, 3'd0);
    chk("midmem rst inst", inst, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst idle", state, 3'd0);

    // run_en dropped during EX: instruction still retires, then idle.
    run_en = 1'b1;
    step();
    chk("drop if", state, 3'd1);
    ifu_ack = 1'b1; ifu_rdata = 32'h00500093;
    step();
    ifu_ack = 1'b0;
    step();
    chk("drop ex", state, 3'd3);
    run_en = 1'b0;
    step();
    chk("drop wb", {state, pc_wen, rf_wen}, {3'd5, 1'b1, 1'b1});
    step();
    chk("drop idle", state, 3'd0);
    step();
    chk("drop idle hold", {state, pc_wen}, {3'd0, 1'b0});
`ifdef YSYX_CTRL_PERF_EN
    chk("perf instret", perf_instret, 64'd1);
    chk("perf cycle", perf_cycle, 64'd4);
`endif
    run_en = 1'b1;
    step();
    chk("rerun if", state, 3'd1);

    // Back-to-back table with run_en held high.
    for (int i = 0; i < 10; i++)
      run_inst(i, vecs[i].ins, vecs[i].ack_wait, vecs[i].exp_mem, vecs[i].exp_wr, vecs[i].exp_rf);

    // ebreak halts after ID without retiring; later acks are ignored.
    chk("ebreak if", state, 3'd1);
    ifu_ack = 1'b1; ifu_rdata = 32'h00100073;
    step();
    ifu_ack = 1'b0;
    chk("ebreak id", state, 3'd2);
    step();
    chk("ebreak halt", {state, halt, bad_inst, bus_err, pc_wen, rf_wen}, {3'd6, 5'b10000});
    ifu_ack = 1'b1; ifu_rdata = 32'h00000013;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ebreak absorb", {state, ifu_req, pc_wen, halt}, {3'd6, 3'b001});
      chk("ebreak inst", inst, 32'h00100073);
    end
    ifu_ack = 1'b0;

    // Illegal opcode.
    do_reset();
    run_en = 1'b1;
    step();
    ifu_ack = 1'b1; ifu_rdata = 32'h0000007F;
    step();
    ifu_ack = 1'b0;
    step();
    chk("illegal halt", {state, halt, bad_inst, bus_err, pc_wen}, {3'd6, 4'b1100});

    // Fetch timeout with no ack: four IF cycles then HALT.
    do_reset();
    run_en = 1'b1;
    step();
    for (int i = 1; i <= TO; i++) begin
      chk($sformatf("to wait%0d", i), {state, ifu_req, halt}, {3'd1, 2'b10});
      step();
    end
    chk("to halt", {state, halt, bus_err, bad_inst, ifu_req}, {3'd6, 4'b1100});

    // Ack on the fourth wait cycle wins over the timeout.
    do_reset();
    run_en = 1'b1;
    step();
    for (int i = 1; i < TO; i++) begin
      chk($sformatf("race wait%0d", i), state, 3'd1);
      step();
    end
    ifu_ack = 1'b1; ifu_rdata = 32'h00500093;
    step();
    ifu_ack = 1'b0;
    chk("race id", {state, halt, bus_err}, {3'd2, 2'b00});
    chk("race inst", inst, 32'h00500093);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
